// File: rtl/ex_mem_stage_pkg.sv
// EX/MEM stage shared definitions.
// Width defaults, control-bundle bit indices, register-zero constant.
package ex_mem_stage_pkg;

    localparam int N_DEF  = 32;
    localparam int RW_DEF = 5;

    // Control bundle {regwrite, memread, memwrite, branch, branch_ne}
    localparam int CTRL_W      = 5;
    localparam int C_REGWRITE  = 4;
    localparam int C_MEMREAD   = 3;
    localparam int C_MEMWRITE  = 2;
    localparam int C_BRANCH    = 1;
    localparam int C_BRANCH_NE = 0;

    localparam logic [RW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side inputs, MEM-side outputs, forwarding.
// slave = the stage itself, master = the surrounding pipeline.
interface ex_mem_if #(
    parameter int N  = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  alu_res_i;
    logic          alu_z_i;
    logic [N-1:0]  store_i;
    logic [RW-1:0] rd_i;
    logic          regwrite_i;
    logic          memread_i;
    logic          memwrite_i;
    logic          branch_i;
    logic          branch_ne_i;
    logic [N-1:0]  target_i;
    logic          stall_i;
    logic          flush_i;
    logic          out_valid;
    logic [N-1:0]  alu_res_o;
    logic [N-1:0]  store_o;
    logic [RW-1:0] rd_o;
    logic          regwrite_o;
    logic          memread_o;
    logic          memwrite_o;
    logic          take_branch_o;
    logic [N-1:0]  target_o;
    logic          fwd_valid_o;
    logic [RW-1:0] fwd_rd_o;
    logic [N-1:0]  fwd_data_o;

    modport slave (
        input  in_valid, alu_res_i, alu_z_i, store_i, rd_i,
        input  regwrite_i, memread_i, memwrite_i,
        input  branch_i, branch_ne_i, target_i,
        input  stall_i, flush_i,
        output in_ready, out_valid, alu_res_o, store_o, rd_o,
        output regwrite_o, memread_o, memwrite_o,
        output take_branch_o, target_o,
        output fwd_valid_o, fwd_rd_o, fwd_data_o
    );

    modport master (
        output in_valid, alu_res_i, alu_z_i, store_i, rd_i,
        output regwrite_i, memread_i, memwrite_i,
        output branch_i, branch_ne_i, target_i,
        output stall_i, flush_i,
        input  in_ready, out_valid, alu_res_o, store_o, rd_o,
        input  regwrite_o, memread_o, memwrite_o,
        input  take_branch_o, target_o,
        input  fwd_valid_o, fwd_rd_o, fwd_data_o
    );

endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// beq/bne resolution from the ALU zero flag.
// Wrong-path (squashed) or invalid instructions never take.
module branch_resolve (
    input  logic valid_i,
    input  logic squash_i,
    input  logic branch_i,
    input  logic branch_ne_i,
    input  logic z_i,
    output logic take_o
);

    assign take_o = valid_i & ~squash_i & branch_i
                  & (z_i ^ branch_ne_i);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolve, squash and forwarding.
// Optional branch counters enabled by macro BRANCH_STATS_EN.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RW = RW_DEF
) (
    input  logic clk,
    input  logic rst,
    ex_mem_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_taken_cnt,
    output logic [31:0] br_nt_cnt
`endif
);

    logic              valid_q, valid_d;
    logic              squash_q, squash_d;
    logic              take_q, take_d;
    logic [N-1:0]      alu_q, alu_d;
    logic [N-1:0]      store_q, store_d;
    logic [N-1:0]      tgt_q, tgt_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic [CTRL_W-1:0] ctrl_in;
    logic              load;
    logic              take;

    assign ctrl_in[C_REGWRITE]  = bus.regwrite_i;
    assign ctrl_in[C_MEMREAD]   = bus.memread_i;
    assign ctrl_in[C_MEMWRITE]  = bus.memwrite_i;
    assign ctrl_in[C_BRANCH]    = bus.branch_i;
    assign ctrl_in[C_BRANCH_NE] = bus.branch_ne_i;

    assign load = ~bus.stall_i & ~bus.flush_i;

    branch_resolve u_br (
        .valid_i     (bus.in_valid),
        .squash_i    (squash_q),
        .branch_i    (ctrl_in[C_BRANCH]),
        .branch_ne_i (ctrl_in[C_BRANCH_NE]),
        .z_i         (bus.alu_z_i),
        .take_o      (take)
    );

    // Next state: flush kills, stall holds (pulse drops), load captures.
    always_comb begin
        valid_d  = valid_q;
        squash_d = squash_q;
        take_d   = take_q;
        alu_d    = alu_q;
        store_d  = store_q;
        tgt_d    = tgt_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        if (bus.flush_i) begin
            valid_d  = 1'b0;
            squash_d = 1'b0;
            take_d   = 1'b0;
        end else if (bus.stall_i) begin
            take_d = 1'b0;
        end else begin
            valid_d  = bus.in_valid & ~squash_q;
            // take is gated by squash, so this both sets and consumes it
            squash_d = take;
            take_d   = take;
            alu_d    = bus.alu_res_i;
            store_d  = bus.store_i;
            tgt_d    = bus.target_i;
            rd_d     = bus.rd_i;
            rw_d     = ctrl_in[C_REGWRITE];
            mr_d     = ctrl_in[C_MEMREAD];
            mw_d     = ctrl_in[C_MEMWRITE];
        end
    end

    // Stage registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
            take_q   <= 1'b0;
            alu_q    <= '0;
            store_q  <= '0;
            tgt_q    <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            squash_q <= squash_d;
            take_q   <= take_d;
            alu_q    <= alu_d;
            store_q  <= store_d;
            tgt_q    <= tgt_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
        end
    end

    assign bus.in_ready      = ~bus.stall_i;
    assign bus.out_valid     = valid_q;
    assign bus.alu_res_o     = alu_q;
    assign bus.store_o       = store_q;
    assign bus.rd_o          = rd_q;
    assign bus.regwrite_o    = valid_q & rw_q;
    assign bus.memread_o     = valid_q & mr_q;
    assign bus.memwrite_o    = valid_q & mw_q;
    assign bus.take_branch_o = take_q;
    assign bus.target_o      = tgt_q;
    assign bus.fwd_valid_o   = valid_q & rw_q
                             & (rd_q != RW'(REG_ZERO));
    assign bus.fwd_rd_o      = rd_q;
    assign bus.fwd_data_o    = alu_q;

`ifdef BRANCH_STATS_EN
    logic br_seen;

    assign br_seen = bus.in_valid & ~squash_q & ctrl_in[C_BRANCH];

    // Count resolved branches as they are loaded; flush never loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_taken_cnt <= '0;
            br_nt_cnt    <= '0;
        end else if (load && br_seen) begin
            if (take) br_taken_cnt <= br_taken_cnt + 32'd1;
            else      br_nt_cnt    <= br_nt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// Counter checks compile in only with BRANCH_STATS_EN.
module tb_ex_mem_stage;

    logic clk;
    logic rst;
    int   vecs;
    int   miss;

    ex_mem_if #(.N(32), .RW(5)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] br_taken_cnt;
    logic [31:0] br_nt_cnt;
`endif

    ex_mem_stage #(.N(32), .RW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRANCH_STATS_EN
        ,
        .br_taken_cnt (br_taken_cnt),
        .br_nt_cnt    (br_nt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v,
                       input logic [31:0] alu,
                       input logic z,
                       input logic [31:0] st,
                       input logic [4:0] rd,
                       input logic rw,
                       input logic mr,
                       input logic mw,
                       input logic br,
                       input logic bne,
                       input logic [31:0] tgt);
        bus.in_valid    = v;
        bus.alu_res_i   = alu;
        bus.alu_z_i     = z;
        bus.store_i     = st;
        bus.rd_i        = rd;
        bus.regwrite_i  = rw;
        bus.memread_i   = mr;
        bus.memwrite_i  = mw;
        bus.branch_i    = br;
        bus.branch_ne_i = bne;
        bus.target_i    = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = 0;
        miss = 0;
        rst = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_take", bus.take_branch_o, 0);
        chk("rst_alu", bus.alu_res_o, 0);
        chk("rst_tgt", bus.target_o, 0);
        chk("rst_rw", bus.regwrite_o, 0);
        rst = 1'b0;

        // plain load, 1-cycle latency
        drv(1, 32'h11, 0, 32'hAA, 3, 1, 1, 0, 0, 0, 0);
        tick();
        chk("ld_valid", bus.out_valid, 1);
        chk("ld_alu", bus.alu_res_o, 32'h11);
        chk("ld_store", bus.store_o, 32'hAA);
        chk("ld_mr", bus.memread_o, 1);
        chk("ld_fwdv", bus.fwd_valid_o, 1);
        chk("ld_fwdrd", bus.fwd_rd_o, 3);
        chk("ld_ready", bus.in_ready, 1);

        // beq taken
        drv(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0020);
        tick();
        chk("beq_take", bus.take_branch_o, 1);
        chk("beq_tgt", bus.target_o, 32'h0040_0020);
        chk("beq_valid", bus.out_valid, 1);
        drv(1, 32'h22, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        tick();
        chk("sq_valid", bus.out_valid, 0);
        chk("sq_fwdv", bus.fwd_valid_o, 0);
        chk("sq_rw", bus.regwrite_o, 0);
        chk("sq_take", bus.take_branch_o, 0);

        // bne not taken
        drv(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0100);
        tick();
        chk("bne_take", bus.take_branch_o, 0);
        chk("bne_valid", bus.out_valid, 1);
        drv(1, 32'h5, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        tick();
        chk("bne_nxt_v", bus.out_valid, 1);
        chk("bne_nxt_d", bus.fwd_data_o, 32'h5);
        chk("bne_nxt_fv", bus.fwd_valid_o, 1);
        chk("bne_nxt_rd", bus.fwd_rd_o, 9);

        // stall hold with a taken branch in the register
        drv(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0040);
        tick();
        chk("st_take0", bus.take_branch_o, 1);
        chk("st_alu0", bus.alu_res_o, 32'hDEAD_BEEF);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'h1234 + i, 0, 0, 11, 1, 0, 0, 1, 0, 32'h100);
            tick();
            chk("st_alu", bus.alu_res_o, 32'hDEAD_BEEF);
            chk("st_take", bus.take_branch_o, 0);
            chk("st_valid", bus.out_valid, 1);
            chk("st_tgt", bus.target_o, 32'h0040_0040);
            chk("st_ready", bus.in_ready, 0);
        end
        bus.stall_i = 1'b0;
        drv(1, 32'h77, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        tick();
        chk("st_sq_valid", bus.out_valid, 0);
        drv(1, 32'h78, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        tick();
        chk("st_post_v", bus.out_valid, 1);
        chk("st_post_d", bus.fwd_data_o, 32'h78);

        // flush over stall clears pending squash
        drv(1, 32'hC0, 1, 32'h5A5A, 0, 0, 0, 1, 1, 0, 32'h0040_0080);
        tick();
        chk("fl_take0", bus.take_branch_o, 1);
        chk("fl_mw0", bus.memwrite_o, 1);
        chk("fl_store0", bus.store_o, 32'h5A5A);
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        drv(1, 32'h33, 0, 0, 2, 1, 0, 1, 0, 0, 0);
        tick();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_mw", bus.memwrite_o, 0);
        chk("fl_take", bus.take_branch_o, 0);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        drv(1, 32'h99, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        tick();
        chk("fl_post_v", bus.out_valid, 1);
        chk("fl_post_d", bus.fwd_data_o, 32'h99);
        chk("fl_post_fv", bus.fwd_valid_o, 1);

        // register $zero never forwards
        drv(1, 32'h7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("z_valid", bus.out_valid, 1);
        chk("z_rw", bus.regwrite_o, 1);
        chk("z_fwdv", bus.fwd_valid_o, 0);

`ifdef BRANCH_STATS_EN
        chk("cnt_taken", br_taken_cnt, 3);
        chk("cnt_nt", br_nt_cnt, 1);
`endif

        // async reset while stalled
        drv(1, 32'h55, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        tick();
        bus.stall_i = 1'b1;
        tick();
        chk("ar_pre_v", bus.out_valid, 1);
        chk("ar_pre_d", bus.alu_res_o, 32'h55);
        rst = 1'b1;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_take", bus.take_branch_o, 0);
        chk("ar_alu", bus.alu_res_o, 0);
`ifdef BRANCH_STATS_EN
        chk("ar_cnt_t", br_taken_cnt, 0);
        chk("ar_cnt_n", br_nt_cnt, 0);
`endif
        #1;
        rst = 1'b0;
        bus.stall_i = 1'b0;
        drv(1, 32'h66, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        tick();
        chk("ar_post_v", bus.out_valid, 1);
        chk("ar_post_d", bus.alu_res_o, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miss);
        $finish;
    end

endmodule
